rng_key_collector: RTL and testbench
====================================

# rng_key_collector

Upstream feeder of the SIMON key RAM. It takes raw entropy bits from the ring-oscillator sampler, debiases them with a von Neumann extractor and packs them into 32-bit words. On each `key_we`/`key_addr` request it writes one word to the key RAM and answers with a one-cycle `key_ack`. The cipher then reads those two words as its 64-bit key. An optional repetition-count health test flags a stuck entropy source.

## Interface
- `WORD_W`, 32: width of assembled word and RAM data.
- `ADDR_W`, 9: key RAM address width.
- `REP_LIMIT`, 31: number of consecutive identical raw samples that trips the health test; legal range 2..255.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `raw_bit`  in  1  entropy sample.
- `raw_valid`  in  1  `raw_bit` is valid this cycle.
- `key_we`  in  1  word request; level, held high until `key_ack`.
- `key_addr`  in  ADDR_W  target RAM address; sampled when a request is accepted.
- `key_ack`  out  1  one-cycle completion pulse.
- `key_err`  out  1  valid with `key_ack`; 1 means the word was not written (health failure).
- `ram_we`  out  1  RAM write strobe, one cycle.
- `ram_addr`  out  ADDR_W  RAM write address.
- `ram_wdata`  out  WORD_W  RAM write data.
- `stuck_err`  out  1  sticky health-test failure.

## Operation
- FSM states: IDLE, COLLECT, WRITE, ACK.
- IDLE
  - `key_we`=1 and `stuck_err`=0: latch `key_addr`, clear the bit counter and pair phase, go to COLLECT.
  - `key_we`=1 and `stuck_err`=1: go to ACK with `key_err`=1.
- COLLECT: each `raw_valid` sample alternates the pair phase.
  - Phase 0: store the first bit.
  - Phase 1: evaluate the pair. 01 emits 0, 10 emits 1, 00/11 are discarded.
  - Emitted bits shift in at the LSB (shift left), so the first emitted bit ends up in bit 31.
  - When the 32nd bit is emitted, go to WRITE.
  - If `stuck_err` rises during COLLECT, go to ACK with `key_err`=1; no write.
- WRITE: `ram_we`=1 with the latched address and the assembled word for exactly one cycle, then ACK.
- ACK: `key_ack`=1 for one cycle, `key_err` per the path taken, then IDLE. IDLE always lasts at least one cycle, so a `key_we` still high in the ACK cycle is not re-accepted until the next IDLE edge.
- Raw samples outside COLLECT are dropped by the extractor. The health counter still sees them.
- Health test
  - Counts consecutive equal `raw_valid` samples. The first sample counts as 1, a change reloads 1, and the count saturates.
  - Count reaching `REP_LIMIT` sets `stuck_err`. It is cleared only by reset.
- `key_addr` changes after acceptance are ignored.

## Timing
- Reset values:
  - Outputs `key_ack`, `key_err`, `ram_we`, `stuck_err` = 0.
  - `ram_addr`, `ram_wdata` = 0.
  - Internal state: FSM in IDLE; counters, shift register and pair phase cleared.
- Latency with `raw_valid` high every cycle and no discarded pairs:
  - Acceptance edge to entering WRITE: 64 cycles.
  - `ram_we` follows in the next cycle, then `key_ack` in the cycle after.
- `ram_wdata`/`ram_addr` hold their values after WRITE until the next WRITE.
- Reset mid-COLLECT or mid-WRITE: immediate return to IDLE. The partial word is lost, and no `ram_we` or `key_ack` follows.
- Bit counter is 6 bits wide, so there is no wrap at 32.

## Configuration
- `RNG_HEALTH_EN` defined: the repetition-count test is present as described above.
- `RNG_HEALTH_EN` undefined: no health counter; `stuck_err` and `key_err` are tied to 0, and every request ends in WRITE then ACK.

## Test plan
- Request addr 0x10 with raw pattern 0,1 repeating, `raw_valid`=1: `ram_we` with addr 0x10, data 0x00000000, then `key_ack`; acceptance to `key_ack` = 66 cycles.
- Request addr 0x11 with pairs 01,10 alternating: data 0x55555555. Pairs 10 only: data 0xFFFFFFFF.
- Insert 00 and 11 pairs between 01/10 pairs with `raw_valid` gapped: identical data to the clean run, and the extra latency equals the discarded and idle samples.
- `RNG_HEALTH_EN`, `raw_bit`=1 held for 31 samples during COLLECT: `stuck_err`=1, then `key_ack`=`key_err`=1 with no `ram_we`. A later request gets an immediate ack with `key_err`=1.
- Reset pulsed 10 cycles into COLLECT: all outputs 0, no write. A fresh request with the 0,1 pattern writes 0x00000000.
- Two back-to-back requests (0x10 then 0x11), with `key_we` dropped the cycle after ack: exactly two writes and two acks.

Source files
------------

// File: rtl/rng_key_collector.sv
// Von Neumann-debiased entropy collector feeding 32-bit words into the SIMON key RAM.
// Optional repetition-count health test is built when RNG_HEALTH_EN is defined.
module rng_key_collector #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned REP_LIMIT = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              raw_bit,
  input  logic              raw_valid,
  input  logic              key_we,
  input  logic [ADDR_W-1:0] key_addr,
  output logic              key_ack,
  output logic              key_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_wdata,
  output logic              stuck_err
);

  localparam int unsigned CNT_W = $clog2(WORD_W) + 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    ACK
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   shift_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic                phase_q;
  logic                first_q;
  logic                err_path_q;
  logic                key_ack_q;
  logic                key_err_q;
  logic                ram_we_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [WORD_W-1:0]   ram_wdata_q;
  logic                stuck;

  // Limits outside 2..255 cannot be represented by the 8-bit saturating counter.
  if (REP_LIMIT < 2 || REP_LIMIT > 255) begin : g_rep_limit_out_of_range
  end

`ifdef RNG_HEALTH_EN
  logic [7:0] rep_cnt_q, rep_cnt_d;
  logic       last_bit_q;
  logic       stuck_q;

  always_comb begin
    rep_cnt_d = rep_cnt_q;
    if (raw_valid) begin
      if (rep_cnt_q == 8'd0 || raw_bit != last_bit_q) begin
        rep_cnt_d = 8'd1;
      end else if (rep_cnt_q != 8'hFF) begin
        rep_cnt_d = rep_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt_q  <= '0;
      last_bit_q <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      if (raw_valid) begin
        last_bit_q <= raw_bit;
        if (rep_cnt_d >= 8'(REP_LIMIT)) begin
          stuck_q <= 1'b1;
        end
      end
    end
  end

  assign stuck = stuck_q;
`else
  assign stuck = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      phase_q     <= 1'b0;
      first_q     <= 1'b0;
      err_path_q  <= 1'b0;
      key_ack_q   <= 1'b0;
      key_err_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      ram_we_q  <= 1'b0;
      key_ack_q <= 1'b0;
      key_err_q <= 1'b0;
      unique case (state_q)
        // key_ack_q is still high in the first IDLE cycle, so a held request waits one more edge.
        IDLE: begin
          if (key_we && !key_ack_q) begin
            if (stuck) begin
              err_path_q <= 1'b1;
              state_q    <= ACK;
            end else begin
              err_path_q <= 1'b0;
              addr_q     <= key_addr;
              shift_q    <= '0;
              bit_cnt_q  <= '0;
              phase_q    <= 1'b0;
              state_q    <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (stuck) begin
            err_path_q <= 1'b1;
            state_q    <= ACK;
          end else if (raw_valid) begin
            if (!phase_q) begin
              first_q <= raw_bit;
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              // 01 emits 0, 10 emits 1: the emitted bit equals the first of the pair.
              if (first_q != raw_bit) begin
                shift_q   <= {shift_q[WORD_W-2:0], first_q};
                bit_cnt_q <= bit_cnt_q + 1'b1;
                if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
                  state_q <= WRITE;
                end
              end
            end
          end
        end
        WRITE: begin
          ram_we_q    <= 1'b1;
          ram_addr_q  <= addr_q;
          ram_wdata_q <= shift_q;
          state_q     <= ACK;
        end
        ACK: begin
          key_ack_q <= 1'b1;
          key_err_q <= err_path_q;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_ack   = key_ack_q;
  assign key_err   = key_err_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign stuck_err = stuck;

endmodule

// File: tb/tb_rng_key_collector.sv
// Scoreboard bench for rng_key_collector: requests push expected writes/acks, a negedge monitor pops them.
module tb_rng_key_collector;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              raw_bit = 1'b0;
  logic              raw_valid = 1'b0;
  logic              key_we = 1'b0;
  logic [ADDR_W-1:0] key_addr = '0;
  logic              key_ack;
  logic              key_err;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata;
  logic              stuck_err;

  rng_key_collector #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .REP_LIMIT(31)) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_bit   (raw_bit),
    .raw_valid (raw_valid),
    .key_we    (key_we),
    .key_addr  (key_addr),
    .key_ack   (key_ack),
    .key_err   (key_err),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .stuck_err (stuck_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
    logic              err;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] src_q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         wr_cnt = 0;
  int         ack_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Raw sample driver: one {valid,bit} entry per cycle.
  initial begin
    logic [1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (src_q.size() != 0) begin
        e = src_q.pop_front();
        raw_valid = e[1];
        raw_bit   = e[0];
      end else begin
        raw_valid = 1'b0;
        raw_bit   = 1'b0;
      end
    end
  end

  initial begin
    exp_t f;
    forever begin
      @(negedge clk);
      if (ram_we) begin
        wr_cnt++;
        check_eq("we_sb_pending", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          f = sb[0];
          check_eq("we_allowed", 64'(f.err), 64'd0);
          check_eq("we_addr", 64'(ram_addr), 64'(f.addr));
          check_eq("we_data", 64'(ram_wdata), 64'(f.data));
        end
      end
      if (key_ack) begin
        ack_cnt++;
        check_eq("ack_sb_pending", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          f = sb.pop_front();
          check_eq("ack_err", 64'(key_err), 64'(f.err));
        end
      end
    end
  end

  // Each word bit b becomes the pair (b, ~b); junk pairs and gaps add to extra.
  task automatic push_word(input logic [WORD_W-1:0] w, input bit junk, output int extra);
    logic b;
    logic jb;
    extra = 0;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      b = w[i];
      if (junk && (i % 3 == 1)) begin
        jb = (i % 2 == 1);
        src_q.push_back({1'b1, jb});
        src_q.push_back({1'b1, jb});
        extra += 2;
      end
      src_q.push_back({1'b1, b});
      if (junk && (i % 4 == 2)) begin
        src_q.push_back({1'b0, ~b});
        extra++;
      end
      src_q.push_back({1'b1, ~b});
    end
  endtask

  // mode: 0 clean stream, 1 stream with junk pairs/gaps, 2 constant ones, 3 no samples.
  task automatic run_req(input logic [ADDR_W-1:0] addr, input logic [WORD_W-1:0] word,
                         input int mode, input bit exp_err, input int exp_lat, input int hold_extra);
    int acc;
    int a0;
    int extra;
    int n;
    @(posedge clk);
    #1;
    key_we   = 1'b1;
    key_addr = addr;
    acc      = cyc + 1;
    a0       = ack_cnt;
    sb.push_back('{addr: addr, data: word, err: exp_err});
    @(posedge clk);
    extra = 0;
    if (mode == 0 || mode == 1) push_word(word, (mode == 1), extra);
    else if (mode == 2) for (int i = 0; i < 40; i++) src_q.push_back(2'b11);
    #1;
    key_addr = ~addr;
    n = 0;
    while (ack_cnt == a0 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("ack_seen", 64'(ack_cnt - a0), 64'd1);
    if (exp_lat >= 0) check_eq("latency", 64'(cyc - acc), 64'(exp_lat + extra));
    for (int i = 0; i < hold_extra; i++) begin
      @(posedge clk);
      #1;
    end
    key_we = 1'b0;
    src_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int a0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_key_ack", 64'(key_ack), 64'd0);
    check_eq("rst_key_err", 64'(key_err), 64'd0);
    check_eq("rst_ram_we", 64'(ram_we), 64'd0);
    check_eq("rst_stuck_err", 64'(stuck_err), 64'd0);
    check_eq("rst_ram_addr", 64'(ram_addr), 64'd0);
    check_eq("rst_ram_wdata", 64'(ram_wdata), 64'd0);
    rst = 1'b1;

    run_req(9'h010, 32'h0000_0000, 0, 1'b0, 66, 0);
    run_req(9'h011, 32'h5555_5555, 0, 1'b0, 66, 0);
    check_eq("hold_ram_addr", 64'(ram_addr), 64'h011);
    check_eq("hold_ram_wdata", 64'(ram_wdata), 64'h5555_5555);
    run_req(9'h012, 32'hFFFF_FFFF, 0, 1'b0, 66, 0);
    run_req(9'h013, 32'h5555_5555, 1, 1'b0, 66, 0);
    run_req(9'h0A5, 32'hC3A5_1E96, 1, 1'b0, 66, 0);

    // Reset 10 cycles into COLLECT: nothing may follow.
    w0 = wr_cnt;
    a0 = ack_cnt;
    @(posedge clk);
    #1;
    key_we   = 1'b1;
    key_addr = 9'h030;
    @(posedge clk);
    for (int i = 0; i < 40; i++) src_q.push_back({1'b1, 1'(i % 2)});
    repeat (10) @(posedge clk);
    #1;
    rst    = 1'b0;
    key_we = 1'b0;
    src_q.delete();
    @(negedge clk);
    check_eq("midrst_ram_we", 64'(ram_we), 64'd0);
    check_eq("midrst_key_ack", 64'(key_ack), 64'd0);
    check_eq("midrst_ram_addr", 64'(ram_addr), 64'd0);
    check_eq("midrst_ram_wdata", 64'(ram_wdata), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (80) @(posedge clk);
    @(negedge clk);
    check_eq("midrst_no_write", 64'(wr_cnt - w0), 64'd0);
    check_eq("midrst_no_ack", 64'(ack_cnt - a0), 64'd0);
    run_req(9'h010, 32'h0000_0000, 0, 1'b0, 66, 0);

    // Back-to-back, key_we held through the cycle after ack.
    w0 = wr_cnt;
    a0 = ack_cnt;
    run_req(9'h010, 32'h0000_0000, 0, 1'b0, 66, 1);
    run_req(9'h011, 32'h5555_5555, 0, 1'b0, 66, 1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_eq("b2b_writes", 64'(wr_cnt - w0), 64'd2);
    check_eq("b2b_acks", 64'(ack_cnt - a0), 64'd2);

`ifdef RNG_HEALTH_EN
    w0 = wr_cnt;
    run_req(9'h020, 32'h0000_0000, 2, 1'b1, -1, 0);
    @(negedge clk);
    check_eq("stuck_set", 64'(stuck_err), 64'd1);
    check_eq("stuck_no_write", 64'(wr_cnt - w0), 64'd0);
    run_req(9'h021, 32'h0000_0000, 3, 1'b1, 1, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("stuck_sticky", 64'(stuck_err), 64'd1);
    check_eq("stuck_still_no_write", 64'(wr_cnt - w0), 64'd0);
`else
    @(negedge clk);
    check_eq("stuck_tied_low", 64'(stuck_err), 64'd0);
`endif
    check_eq("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
